env_vca: RTL

- ADSR envelope generator plus voltage-controlled amplifier (VCA) stage.
- Sits between the sine generator output and the SPI DAC D input.
- Scales the 18-bit signed sine sample by a 16-bit envelope, advancing one step per DAC sample strobe (ena from the SPI I/O block).
- Output is 12-bit offset binary, ready for the DAC input port.

---
 rtl/env_pkg.sv | 18 +
 rtl/vca_mult.sv | 59 +++++
 rtl/env_vca.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/env_pkg.sv
// Shared constants for the ADSR envelope / VCA block: FSM encoding,
// envelope step scaling and the offset-binary conversion constant.
package env_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } adsr_state_e;

  // step(r) = (r + 1) << STEP_SHIFT, spanning 16..4096 for an 8-bit rate
  localparam int STEP_SHIFT = 4;

  localparam logic [11:0] OB_FLIP = 12'h800;

endpackage

// File: rtl/vca_mult.sv
// VCA back end: registered signed-sample x unsigned-envelope multiply,
// then truncation to offset binary. Accepts one sample per clk.
module vca_mult
  import env_pkg::*;
#(
  parameter int DSZ = 18,
  parameter int ESZ = 16,
  parameter int OSZ = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic signed [DSZ-1:0] din,
  input  logic        [ESZ-1:0] env,
  output logic        [OSZ-1:0] dout,
  output logic                  dout_valid
);

  localparam int PW = DSZ + ESZ + 1;

  logic signed [PW-1:0]  prod;
  logic signed [DSZ-1:0] y_d, y_q;
  logic                  v2_d, v2_q;
  logic        [OSZ-1:0] dout_d, dout_q;
  logic                  dout_valid_d, dout_valid_q;
  logic                  unused_bits;

  always_comb begin
    // Zero-extended envelope keeps the multiply signed x non-negative.
    prod         = PW'(din) * PW'($signed({1'b0, env}));
    y_d          = y_q;
    v2_d         = in_valid;
    dout_d       = dout_q;
    dout_valid_d = v2_q;
    if (in_valid) y_d = prod[PW-2 -: DSZ];
    if (v2_q)     dout_d = y_q[DSZ-1 -: OSZ] ^ OSZ'(OB_FLIP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_q          <= '0;
      v2_q         <= 1'b0;
      dout_q       <= OSZ'(OB_FLIP);
      dout_valid_q <= 1'b0;
    end else begin
      y_q          <= y_d;
      v2_q         <= v2_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // The product sign bit and the low fraction bits are dropped by design.
  assign unused_bits = ^{prod[PW-1], y_q[DSZ-OSZ-1:0]};

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: rtl/env_vca.sv
// ADSR envelope generator stepping once per DAC sample strobe, feeding a
// VCA that scales the sine sample and emits 12-bit offset binary.
module env_vca
  import env_pkg::*;
#(
  parameter int DSZ = 18,
  parameter int ESZ = 16,
  parameter int OSZ = 12,
  parameter int RSZ = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ena,
  input  logic                  gate,
  input  logic        [RSZ-1:0] attack_rate,
  input  logic        [RSZ-1:0] decay_rate,
  input  logic        [RSZ-1:0] sustain_lvl,
  input  logic        [RSZ-1:0] release_rate,
  input  logic signed [DSZ-1:0] din,
  output logic        [OSZ-1:0] dout,
  output logic                  dout_valid,
  output logic        [ESZ-1:0] env,
  output logic                  busy
);

  localparam int EW = ESZ + 1;
  localparam logic [EW-1:0] ENV_MAX = {1'b0, {ESZ{1'b1}}};

  function automatic logic [EW-1:0] step_of(input logic [RSZ-1:0] r);
    return (EW'(r) + EW'(1)) << STEP_SHIFT;
  endfunction

  adsr_state_e           state_d, state_q;
  logic        [ESZ-1:0] env_d, env_q;
  logic                  gate_d, gate_q, g_prev_d, g_prev_q;
  logic signed [DSZ-1:0] din_cap_d, din_cap_q;
  logic        [ESZ-1:0] env_cap_d, env_cap_q;
  logic                  s1_valid_d, s1_valid_q;

  logic                  rise, fall;
  logic        [EW-1:0]  sus_lvl, attack_sum, decay_step, decay_floor, release_step;

  assign rise = gate_q & ~g_prev_q;
  assign fall = ~gate_q & g_prev_q;

  // Gate history and VCA stage 1 both advance only on the sample strobe.
  always_comb begin
    // NOTE: every variable gets a default first, so no path infers a latch.
    gate_d     = gate_q;
    g_prev_d   = g_prev_q;
    din_cap_d  = din_cap_q;
    env_cap_d  = env_cap_q;
    s1_valid_d = ena;
    if (ena) begin
      gate_d    = gate;
      g_prev_d  = gate_q;
      din_cap_d = din;
      env_cap_d = env_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    env_d        = env_q;
    sus_lvl      = EW'({sustain_lvl, sustain_lvl});
    attack_sum   = EW'(env_q) + step_of(attack_rate);
    decay_step   = step_of(decay_rate);
    decay_floor  = sus_lvl + decay_step;
    release_step = step_of(release_rate);
    if (ena) begin
      if (rise) begin
        state_d = ATTACK;
      end else begin
        case (state_q)
          IDLE:    env_d = '0;
          ATTACK:
            if (fall) state_d = RELEASE;
            else if (attack_sum >= ENV_MAX) begin
              env_d   = '1;
              state_d = DECAY;
            end else env_d = attack_sum[ESZ-1:0];
          DECAY:
            if (fall) state_d = RELEASE;
            else if (EW'(env_q) <= decay_floor) begin
              env_d   = sus_lvl[ESZ-1:0];
              state_d = SUSTAIN;
            end else env_d = env_q - decay_step[ESZ-1:0];
          SUSTAIN:
            if (fall) state_d = RELEASE;
            else env_d = sus_lvl[ESZ-1:0];
          RELEASE:
            if (EW'(env_q) <= release_step) begin
              env_d   = '0;
              state_d = IDLE;
            end else env_d = env_q - release_step[ESZ-1:0];
          default: begin
            env_d   = '0;
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      env_q      <= '0;
      gate_q     <= 1'b0;
      g_prev_q   <= 1'b0;
      din_cap_q  <= '0;
      env_cap_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop updates from the pre-edge values.
      state_q    <= state_d;
      env_q      <= env_d;
      gate_q     <= gate_d;
      g_prev_q   <= g_prev_d;
      din_cap_q  <= din_cap_d;
      env_cap_q  <= env_cap_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  assign env = env_q;

  vca_mult #(
    .DSZ(DSZ),
    .ESZ(ESZ),
    .OSZ(OSZ)
  ) u_vca_mult (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (s1_valid_q),
    .din       (din_cap_q),
    .env       (env_cap_q),
    .dout      (dout),
    .dout_valid(dout_valid)
  );

endmodule
